// File: rtl/rpn_cmd_parser.sv
// ASCII RPN character stream to stack-calculator command parser.
// Optional build macro: DIGIT_OVF_ERR_EN (literal overflow is an error instead of wrapping).
module rpn_cmd_parser #(
  parameter int         WIDTH    = 8,
  parameter logic [7:0] SEP_CHAR = 8'h20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_in,
  input  logic             char_valid,
  output logic             char_ready,
  input  logic             calc_valid,
  output logic [2:0]       op,
  output logic [WIDTH-1:0] in,
  output logic             apply,
  output logic             line_done,
  output logic             error
);

  typedef enum logic [1:0] {IDLE, EMIT_NUM, EMIT_OP, ERROR} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             pending;
  logic [2:0]       op_latch;

  logic             accept;
  logic             is_digit;
  logic             is_op;
  logic [2:0]       opcode;
`ifdef DIGIT_OVF_ERR_EN
  logic [WIDTH+3:0] acc_full;
  logic             ovf;
`else
  logic [WIDTH-1:0] acc_full;
`endif

  assign char_ready = (state == IDLE) && calc_valid;
  assign accept     = char_valid && char_ready;
  assign is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);

`ifdef DIGIT_OVF_ERR_EN
  // Extra 4 bits hold acc*10+9 exactly so overflow can be detected.
  assign acc_full = ({4'b0000, acc} << 3) + ({4'b0000, acc} << 1)
                  + (WIDTH+4)'(char_in[3:0]);
  assign ovf      = |acc_full[WIDTH+3:WIDTH];
`else
  assign acc_full = (acc << 3) + (acc << 1) + WIDTH'(char_in[3:0]);
`endif

  always_comb begin
    is_op  = 1'b1;
    opcode = 3'd0;
    case (char_in)
      8'h2B:   opcode = 3'd2;
      8'h2A:   opcode = 3'd3;
      8'h2D:   opcode = 3'd4;
      8'h2F:   opcode = 3'd5;
      8'h25:   opcode = 3'd6;
      8'h64:   opcode = 3'd1;
      default: is_op  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      pending   <= 1'b0;
      op_latch  <= '0;
      op        <= '0;
      in        <= '0;
      apply     <= 1'b0;
      line_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      apply     <= 1'b0;
      line_done <= 1'b0;
      // Loss of calculator valid overrides everything, including a queued EMIT_OP.
      if (state != ERROR && !calc_valid) begin
        state <= ERROR;
        error <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (is_digit) begin
`ifdef DIGIT_OVF_ERR_EN
                if (ovf) begin
                  state <= ERROR;
                  error <= 1'b1;
                end else begin
                  acc     <= acc_full[WIDTH-1:0];
                  pending <= 1'b1;
                end
`else
                acc     <= acc_full;
                pending <= 1'b1;
`endif
              end else if (char_in == SEP_CHAR || char_in == 8'h0A) begin
                if (pending) begin
                  apply   <= 1'b1;
                  op      <= 3'd0;
                  in      <= acc;
                  acc     <= '0;
                  pending <= 1'b0;
                end
                line_done <= (char_in == 8'h0A);
              end else if (is_op) begin
                apply <= 1'b1;
                if (pending) begin
                  op       <= 3'd0;
                  in       <= acc;
                  acc      <= '0;
                  pending  <= 1'b0;
                  op_latch <= opcode;
                  state    <= EMIT_NUM;
                end else begin
                  op <= opcode;
                end
              end else begin
                state <= ERROR;
                error <= 1'b1;
              end
            end
          end
          EMIT_NUM: begin
            apply <= 1'b1;
            op    <= op_latch;
            state <= EMIT_OP;
          end
          EMIT_OP: state <= IDLE;
          ERROR:   error <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rpn_cmd_parser.sv
// Scoreboard bench for rpn_cmd_parser with a small reference stack calculator.
module tb_rpn_cmd_parser;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic       calc_valid;
  logic [2:0] op;
  logic [7:0] cmd_in;
  logic       apply;
  logic       line_done;
  logic       error;

  rpn_cmd_parser #(.WIDTH(8), .SEP_CHAR(8'h20)) dut (
    .clk        (clk),
    .reset      (reset),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .calc_valid (calc_valid),
    .op         (op),
    .in         (cmd_in),
    .apply      (apply),
    .line_done  (line_done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ap;
    logic [2:0] op;
    logic [7:0] val;
    logic       ld;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t mon_e;
  int   stk[$];
  int   m_acc;
  bit   m_pend;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int tail();
    return (stk.size() > 0) ? stk[$] : -1;
  endfunction

  task automatic push_exp(input bit ap, input int o, input int v, input bit ld);
    cmd_t c;
    c.ap = ap; c.op = 3'(o); c.val = 8'(v); c.ld = ld;
    exp_q.push_back(c);
  endtask

  // Reference parser: updated on every accepted character.
  task automatic model_char(input byte c);
    int full;
    int opc;
    opc = -1;
    case (c)
      "+": opc = 2;
      "*": opc = 3;
      "-": opc = 4;
      "/": opc = 5;
      "%": opc = 6;
      "d": opc = 1;
      default: opc = -1;
    endcase
    if (c >= "0" && c <= "9") begin
      full = m_acc * 10 + (c - "0");
`ifdef DIGIT_OVF_ERR_EN
      if (full <= 255) begin m_acc = full; m_pend = 1; end
`else
      m_acc = full % 256; m_pend = 1;
`endif
    end else if (c == 8'h20 || c == 8'h0A) begin
      if (m_pend) push_exp(1, 0, m_acc, c == 8'h0A);
      else if (c == 8'h0A) push_exp(0, 0, 0, 1);
      m_acc = 0; m_pend = 0;
    end else if (opc >= 0) begin
      if (m_pend) push_exp(1, 0, m_acc, 0);
      push_exp(1, opc, 0, 0);
      m_acc = 0; m_pend = 0;
    end
  endtask

  task automatic calc_step();
    int a, b, r;
    case (op)
      3'd0: stk.push_back(int'(cmd_in));
      3'd1: if (stk.size() > 0) void'(stk.pop_back());
      default: if (stk.size() >= 2) begin
        b = stk.pop_back();
        a = stk.pop_back();
        case (op)
          3'd2:    r = a + b;
          3'd3:    r = a * b;
          3'd4:    r = a - b;
          3'd5:    r = (b != 0) ? a / b : 0;
          default: r = (b != 0) ? a % b : 0;
        endcase
        stk.push_back(r & 255);
      end
    endcase
  endtask

  always @(negedge clk) begin
    if (!reset && (apply || line_done)) begin
      if (exp_q.size() == 0) begin
        check("spurious_cmd", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("apply", int'(apply), int'(mon_e.ap));
        check("line_done", int'(line_done), int'(mon_e.ld));
        if (mon_e.ap) check("op", int'(op), int'(mon_e.op));
        if (mon_e.ap && mon_e.op == 3'd0) check("in", int'(cmd_in), int'(mon_e.val));
      end
      if (apply) calc_step();
    end
  end

  task automatic send(input byte c, output int waited);
    @(negedge clk);
    char_in    = c;
    char_valid = 1'b1;
    waited     = 0;
    #1;
    while (!char_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!char_ready) begin
      check("ready_timeout", 0, 1);
    end else begin
      model_char(c);
      @(posedge clk);
    end
    #1 char_valid = 1'b0;
  endtask

  task automatic send_str(input string s, output int maxw);
    int w;
    maxw = 0;
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], w);
      if (w > maxw) maxw = w;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    stk.delete();
    m_acc = 0;
    m_pend = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset      = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    calc_valid = 1'b1;
    m_acc      = 0;
    m_pend     = 0;
    #1;
    check("rst_apply", int'(apply), 0);
    check("rst_error", int'(error), 0);
    check("rst_line_done", int'(line_done), 0);
    check("rst_op", int'(op), 0);
    check("rst_in", int'(cmd_in), 0);
    check("rst_ready", int'(char_ready), 1);
    @(negedge clk);
    reset = 1'b0;

    send_str("4 4+", w);
    idle(4);
    check("4_4_stall", w, 0);
    check("4_4_drain", exp_q.size(), 0);
    check("4_4_tail", tail(), 8);

    do_reset();
    send_str("86 7/", w);
    idle(4);
    check("div_drain", exp_q.size(), 0);
    check("div_tail", tail(), 12);

    do_reset();
    send_str("86 7%", w);
    idle(4);
    check("mod_drain", exp_q.size(), 0);
    check("mod_tail", tail(), 2);

    do_reset();
    send_str("12*", w);
    check("12mul_rdy_c1", int'(char_ready), 0);
    @(posedge clk); #1;
    check("12mul_rdy_c2", int'(char_ready), 0);
    @(posedge clk); #1;
    check("12mul_rdy_c3", int'(char_ready), 1);
    idle(3);
    check("12mul_drain", exp_q.size(), 0);

    do_reset();
`ifdef DIGIT_OVF_ERR_EN
    send_str("300", w);
    idle(3);
    check("ovf_error", int'(error), 1);
    check("ovf_ready", int'(char_ready), 0);
`else
    send_str("300 ", w);
    idle(3);
    check("wrap_tail", tail(), 44);
    check("wrap_error", int'(error), 0);
`endif
    check("ovf_drain", exp_q.size(), 0);

    do_reset();
    send_str("5x", w);
    check("badchar_error", int'(error), 1);
    check("badchar_ready", int'(char_ready), 0);
    idle(3);
    check("badchar_apply", int'(apply), 0);
    check("badchar_drain", exp_q.size(), 0);

    do_reset();
    send_str("9\n\n", w);
    idle(3);
    check("lf_drain", exp_q.size(), 0);
    check("lf_tail", tail(), 9);

    do_reset();
    @(negedge clk);
    char_in    = "1";
    char_valid = 1'b1;
    calc_valid = 1'b0;
    #1;
    check("cv0_ready", int'(char_ready), 0);
    @(posedge clk); #1;
    check("cv0_error", int'(error), 1);
    check("cv0_apply", int'(apply), 0);
    char_valid = 1'b0;
    calc_valid = 1'b1;
    #1;
    check("cv0_sticky_ready", int'(char_ready), 0);
    idle(2);
    check("cv0_sticky_error", int'(error), 1);
    #2 reset = 1'b1;
    #1;
    check("cv0_rst_error", int'(error), 0);
    check("cv0_rst_ready", int'(char_ready), 1);
    exp_q.delete();
    stk.delete();
    m_acc = 0;
    m_pend = 0;
    @(negedge clk);
    reset = 1'b0;
    send_str("7 ", w);
    idle(3);
    check("cv0_after_tail", tail(), 7);
    check("cv0_after_drain", exp_q.size(), 0);

    do_reset();
    send_str("3+", w);
    check("midemit_apply_pre", int'(apply), 1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midemit_apply_rst", int'(apply), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    check("midemit_ready", int'(char_ready), 1);
    check("midemit_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
